// File: rtl/lsu_data_mem_responder.sv
// LSU data-port memory responder: word RAM with fixed-latency, in-order responses.
// Define LSU_MEM_GNT_STALL_EN to add pseudo-random grant stalls driven by an 8-bit LFSR.
module lsu_data_mem_responder #(
  parameter int unsigned MemWords       = 1024,
  parameter logic [31:0] BaseAddr       = 32'h0010_0000,
  parameter int unsigned RespLatency    = 1,
  parameter int unsigned MaxOutstanding = 2
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        data_req_i,
  output logic        data_gnt_o,
  input  logic [31:0] data_addr_i,
  input  logic        data_we_i,
  input  logic [3:0]  data_be_i,
  input  logic [31:0] data_wdata_i,
  output logic        data_rvalid_o,
  output logic [31:0] data_rdata_o,
  output logic        data_err_o
);

  localparam int unsigned IdxW     = $clog2(MemWords);
  localparam logic [32:0] MemBytes = 33'(MemWords) * 33'd4;

  typedef struct packed {
    logic        valid;
    logic        err;
    logic [31:0] rdata;
  } resp_t;

  logic [31:0]     mem [MemWords];
  logic [3:0]      outstanding_q;
  logic [31:0]     offset;
  logic            in_range;
  logic [IdxW-1:0] idx;
  logic            stall;
  logic            grant;
  logic            resp_fire;
  resp_t           resp_new;
  resp_t           pipe_q [RespLatency];

  // The subtraction wraps below BaseAddr, so the lower bound is checked explicitly.
  assign offset   = data_addr_i - BaseAddr;
  assign in_range = (data_addr_i >= BaseAddr) && ({1'b0, offset} < MemBytes);
  assign idx      = offset[IdxW+1:2];

`ifdef LSU_MEM_GNT_STALL_EN
  logic [7:0] lfsr_q;

  // Fibonacci LFSR, taps 8,6,5,4.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      lfsr_q <= 8'hA5;
    end else begin
      lfsr_q <= {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
    end
  end

  assign stall = (lfsr_q[1:0] == 2'b00);
`else
  assign stall = 1'b0;
`endif

  assign grant      = data_req_i & rst_ni & (outstanding_q < 4'(MaxOutstanding)) & ~stall;
  assign data_gnt_o = grant;

  // NOTE: every field gets a default first, so no path through this block infers a latch.
  always_comb begin
    resp_new       = '0;
    resp_new.valid = grant;
    if (grant) begin
      if (!in_range) begin
        resp_new.err = 1'b1;
      end else if (!data_we_i) begin
        resp_new.rdata = mem[idx];
      end
    end
  end

  // NOTE: the RAM array is deliberately left out of reset; only control state is cleared.
  always_ff @(posedge clk_i) begin
    if (grant && data_we_i && in_range) begin
      for (int k = 0; k < 4; k++) begin
        if (data_be_i[k]) begin
          mem[idx][8*k +: 8] <= data_wdata_i[8*k +: 8];
        end
      end
    end
  end

  // NOTE: non-blocking assignments make each stage take its predecessor's old value (a true shift).
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      for (int s = 0; s < int'(RespLatency); s++) begin
        pipe_q[s] <= '0;
      end
    end else begin
      pipe_q[0] <= resp_new;
      for (int s = 1; s < int'(RespLatency); s++) begin
        pipe_q[s] <= pipe_q[s-1];
      end
    end
  end

  assign resp_fire     = pipe_q[RespLatency-1].valid;
  assign data_rvalid_o = resp_fire;
  assign data_err_o    = pipe_q[RespLatency-1].err;
  assign data_rdata_o  = pipe_q[RespLatency-1].rdata;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      outstanding_q <= '0;
    end else begin
      unique case ({grant, resp_fire})
        2'b10:   outstanding_q <= outstanding_q + 4'd1;
        2'b01:   outstanding_q <= outstanding_q - 4'd1;
        default: outstanding_q <= outstanding_q;
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_data_mem_responder.sv
// Bench for lsu_data_mem_responder: two instances (latency 1 and 4) checked against a
// cycle-indexed response model plus directed expectations.
module tb_lsu_data_mem_responder;

  localparam int          WORDS = 1024;
  localparam logic [31:0] BASE  = 32'h0010_0000;
  localparam int          MAXO  = 2;
  localparam int          NC    = 2048;

  logic        clk = 1'b0;
  logic        rst_n, req, we;
  logic [31:0] addr, wdata;
  logic [3:0]  be;
  logic [1:0]  gnt, rvalid, err;
  logic [31:0] rdata [2];

  for (genvar d = 0; d < 2; d++) begin : g_dut
    lsu_data_mem_responder #(
      .MemWords      (WORDS),
      .BaseAddr      (BASE),
      .RespLatency   ((d == 0) ? 1 : 4),
      .MaxOutstanding(MAXO)
    ) u_dut (
      .clk_i        (clk),
      .rst_ni       (rst_n),
      .data_req_i   (req),
      .data_gnt_o   (gnt[d]),
      .data_addr_i  (addr),
      .data_we_i    (we),
      .data_be_i    (be),
      .data_wdata_i (wdata),
      .data_rvalid_o(rvalid[d]),
      .data_rdata_o (rdata[d]),
      .data_err_o   (err[d])
    );
  end

  always #5 clk = ~clk;

  // Reference model: expected response per instance per cycle number.
  bit          ev [2][NC];
  bit          ee [2][NC];
  bit          eu [2][NC];
  bit   [31:0] ed [2][NC];
  bit   [31:0] mm [2][WORDS];
  bit   [3:0]  kn [2][WORDS];
  int          cnt_m [2];

  int       nvec = 0;
  int       nmis = 0;
  int       cyc  = 0;
  bit [1:0] last_gnt, last_rv;

  function automatic int lat(input int d);
    return (d == 0) ? 1 : 4;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nmis++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic drive(input bit r, input bit w, input logic [31:0] a,
                       input logic [3:0] b, input logic [31:0] wd);
    req = r; we = w; addr = a; be = b; wdata = wd;
  endtask

  task automatic cycle();
    bit              eg, inr;
    int              t, idx;
    longint unsigned a;
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      eg = rst_n && req && (cnt_m[d] < MAXO);
      check($sformatf("c%0d.d%0d.gnt", cyc, d), 32'(gnt[d]), 32'(eg));
      last_gnt[d] = gnt[d];
      last_rv[d]  = rvalid[d];
      if (cyc > 0) begin
        check($sformatf("c%0d.d%0d.rvalid", cyc, d), 32'(rvalid[d]), 32'(ev[d][cyc]));
        check($sformatf("c%0d.d%0d.err", cyc, d), 32'(err[d]), 32'(ee[d][cyc]));
        if (!eu[d][cyc]) check($sformatf("c%0d.d%0d.rdata", cyc, d), rdata[d], ed[d][cyc]);
      end
      if (!rst_n) begin
        cnt_m[d] = 0;
        for (int k = 1; k <= 8; k++) begin
          ev[d][cyc+k] = 1'b0; ee[d][cyc+k] = 1'b0; eu[d][cyc+k] = 1'b0; ed[d][cyc+k] = '0;
        end
      end else begin
        if (ev[d][cyc]) cnt_m[d]--;
        if (eg) begin
          cnt_m[d]++;
          t   = cyc + lat(d);
          a   = 64'(addr);
          inr = (a >= 64'(BASE)) && (a < 64'(BASE) + 64'(WORDS) * 4);
          ev[d][t] = 1'b1; ee[d][t] = !inr; eu[d][t] = 1'b0; ed[d][t] = '0;
          if (inr) begin
            idx = int'((a - 64'(BASE)) >> 2);
            if (we) begin
              for (int k = 0; k < 4; k++) begin
                if (be[k]) begin
                  mm[d][idx][8*k +: 8] = wdata[8*k +: 8];
                  kn[d][idx][k] = 1'b1;
                end
              end
            end else begin
              ed[d][t] = mm[d][idx];
              eu[d][t] = (kn[d][idx] != 4'hF);
            end
          end
        end
      end
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic idle(input int n);
    drive(1'b0, 1'b0, BASE, 4'h0, 32'h0);
    repeat (n) cycle();
  endtask

  logic [9:0]  gp;
  logic [11:0] rp;
  logic        rvseen;
  logic [1:0]  g2;

  initial begin
    // Reset held with a pending request.
    rst_n = 1'b0;
    drive(1'b1, 1'b0, BASE + 32'd8, 4'hF, 32'h0);
    repeat (3) begin
      cycle();
      check("rst.gnt", 32'(last_gnt), 32'd0);
    end
    rst_n = 1'b1;
    cycle();
    check("release.gnt", 32'(last_gnt), 32'd3);
    idle(5);

    // Full-word store then load.
    drive(1'b1, 1'b1, BASE + 32'd8, 4'hF, 32'hDEADBEEF);
    cycle();
    check("st.rvalid", 32'(rvalid[0]), 32'd1);
    check("st.rdata", rdata[0], 32'h0);
    drive(1'b1, 1'b0, BASE + 32'd8, 4'hF, 32'h0);
    cycle();
    check("ld.rvalid", 32'(rvalid[0]), 32'd1);
    check("ld.err", 32'(err[0]), 32'd0);
    check("ld.rdata", rdata[0], 32'hDEADBEEF);

    // Partial byte enables, then an all-disabled store.
    drive(1'b1, 1'b1, BASE + 32'd8, 4'b0101, 32'h11223344);
    cycle();
    drive(1'b1, 1'b0, BASE + 32'd8, 4'h0, 32'h0);
    cycle();
    check("be.rdata", rdata[0], 32'hDE22BE44);
    drive(1'b1, 1'b1, BASE + 32'd8, 4'b0000, 32'hFFFFFFFF);
    cycle();
    check("be0.rvalid", 32'(rvalid[0]), 32'd1);
    check("be0.err", 32'(err[0]), 32'd0);
    drive(1'b1, 1'b0, BASE + 32'd8, 4'hF, 32'h0);
    cycle();
    check("be0.rdata", rdata[0], 32'hDE22BE44);
    idle(5);

    // Out-of-range accesses on both sides of the window, and an aliasing store.
    drive(1'b1, 1'b0, BASE + 32'(WORDS * 4), 4'hF, 32'h0);
    cycle();
    check("oor_hi.rvalid", 32'(rvalid[0]), 32'd1);
    check("oor_hi.err", 32'(err[0]), 32'd1);
    check("oor_hi.rdata", rdata[0], 32'h0);
    drive(1'b1, 1'b0, BASE - 32'd4, 4'hF, 32'h0);
    cycle();
    check("oor_lo.err", 32'(err[0]), 32'd1);
    drive(1'b1, 1'b1, BASE, 4'hF, 32'hCAFEF00D);
    cycle();
    drive(1'b1, 1'b1, BASE + 32'(WORDS * 4), 4'hF, 32'h0BADBAD0);
    cycle();
    check("oor_st.err", 32'(err[0]), 32'd1);
    drive(1'b1, 1'b0, BASE, 4'hF, 32'h0);
    cycle();
    check("alias.rdata", rdata[0], 32'hCAFEF00D);
    idle(6);

    // Outstanding limit on the latency-4 instance: req held for 10 cycles.
    drive(1'b1, 1'b0, BASE + 32'd8, 4'hF, 32'h0);
    for (int i = 0; i < 12; i++) begin
      if (i == 10) req = 1'b0;
      cycle();
      if (i < 10) gp[i] = last_gnt[1];
      rp[i] = last_rv[1];
    end
    check("limit.gnt_pattern", 32'(gp), 32'(10'b0001100011));
    check("limit.rvalid_pattern", 32'(rp), 32'(12'b011000110000));

    // Reset one cycle after a grant drops the response and clears the counter.
    drive(1'b1, 1'b0, BASE + 32'd8, 4'hF, 32'h0);
    cycle();
    rst_n = 1'b0;
    req   = 1'b0;
    cycle();
    rvseen = last_rv[1];
    rst_n  = 1'b1;
    repeat (8) begin
      cycle();
      rvseen = rvseen | last_rv[1];
    end
    check("midrst.rvalid", 32'(rvseen), 32'd0);
    drive(1'b1, 1'b0, BASE + 32'd4, 4'hF, 32'h0);
    cycle();
    g2[0] = last_gnt[1];
    cycle();
    g2[1] = last_gnt[1];
    check("midrst.cnt_cleared", 32'(g2), 32'd3);
    idle(6);

    // Randomized traffic around the window edges, with occasional resets.
    for (int i = 0; i < 400; i++) begin
      rst_n = ($urandom_range(0, 63) != 0);
      req   = ($urandom_range(0, 3) != 0);
      we    = 1'($urandom_range(0, 1));
      be    = 4'($urandom);
      wdata = $urandom;
      case ($urandom_range(0, 7))
        0:       addr = BASE + 32'(WORDS * 4) + 32'($urandom_range(0, 15));
        1:       addr = BASE - 32'd1 - 32'($urandom_range(0, 15));
        default: addr = BASE + 32'(4 * $urandom_range(0, 7)) + 32'($urandom_range(0, 3));
      endcase
      cycle();
    end
    rst_n = 1'b1;
    idle(6);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule
